// File: rtl/vga_fb_arbiter.sv
// vga_fb_arbiter
//   Shares one single-port framebuffer RAM (1-cycle read latency) between the
//   display read path and two draw-engine writers. Display reads always win.
//   Writers are served round-robin. An owner may keep writing only up to
//   MAX_BURST consecutive beats while the other writer is waiting.
//
//   Optional feature macro: FB_BLANK_ONLY_EN
//     When defined, writes are granted only while blanking
//     (hcount_i >= HOR_BLANK_START or vcount_i >= VER_BLANK_START).
//     When undefined, hcount_i/vcount_i are ignored.
//
// Ports
//   clk_i, rst_i             clock, synchronous active-high reset
//   hcount_i, vcount_i       display timing position (11b each)
//   rd_req_i, rd_addr_i      display read request / address
//   wr_req_i[1:0]            per-writer valid (addr/data held until accepted)
//   wr_addr{0,1}_i           writer addresses
//   wr_data{0,1}_i           writer data
//   wr_gnt_o[1:0]            per-writer ready (combinational)
//   mem_addr_o, mem_wdata_o  registered RAM address / write data
//   mem_we_o, mem_re_o       registered RAM write / read enables
//   owner_o[1:0]             FSM state: 0 IDLE, 1 OWN0, 2 OWN1
module vga_fb_arbiter #(
  parameter int ADDR_W          = 20,
  parameter int DATA_W          = 12,
  parameter int MAX_BURST       = 4,
  parameter int HOR_BLANK_START = 1024,
  parameter int VER_BLANK_START = 768
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [10:0]       hcount_i,
  input  logic [10:0]       vcount_i,
  input  logic              rd_req_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  input  logic [1:0]        wr_req_i,
  input  logic [ADDR_W-1:0] wr_addr0_i,
  input  logic [ADDR_W-1:0] wr_addr1_i,
  input  logic [DATA_W-1:0] wr_data0_i,
  input  logic [DATA_W-1:0] wr_data1_i,
  output logic [1:0]        wr_gnt_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  output logic              mem_we_o,
  output logic              mem_re_o,
  output logic [1:0]        owner_o
);

  localparam int BW = $clog2(MAX_BURST + 1);
  localparam logic [BW-1:0] MAXB = BW'(MAX_BURST);
  localparam logic [BW-1:0] ONE  = BW'(1);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_OWN0 = 2'd1, S_OWN1 = 2'd2} state_e;

  state_e        state_q, state_d;
  logic [BW-1:0] burst_q, burst_d;
  logic          rr_q, rr_d;
  logic [1:0]    gnt;
  logic          wr_win;
  logic          sel, own, oth;

`ifdef FB_BLANK_ONLY_EN
  assign wr_win = (hcount_i >= 11'(HOR_BLANK_START)) || (vcount_i >= 11'(VER_BLANK_START));
`else
  logic unused_timing;
  assign unused_timing = ^{hcount_i, vcount_i};
  assign wr_win        = 1'b1;
`endif

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      burst_q <= '0;
      rr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      burst_q <= burst_d;
      rr_q    <= rr_d;
    end
  end

  // Next-state / grant decision. Any cycle where writes are not allowed
  // (reset, display read, active video) freezes state and burst count.
  always_comb begin
    state_d = state_q;
    burst_d = burst_q;
    rr_d    = rr_q;
    gnt     = 2'b00;
    own     = (state_q == S_OWN1);
    oth     = ~own;
    sel     = wr_req_i[1] && (!wr_req_i[0] || rr_q);
    if (!rst_i && !rd_req_i && wr_win) begin
      case (state_q)
        S_IDLE: begin
          if (wr_req_i != 2'b00) begin
            gnt[sel] = 1'b1;
            state_d  = sel ? S_OWN1 : S_OWN0;
            burst_d  = ONE;
          end
        end
        S_OWN0, S_OWN1: begin
          if (wr_req_i[own] && (burst_q < MAXB || !wr_req_i[oth])) begin
            gnt[own] = 1'b1;
            if (burst_q < MAXB) burst_d = burst_q + ONE;
          end else if (wr_req_i[oth]) begin
            // hand over in the same cycle (owner dropped or hit its cap)
            gnt[oth] = 1'b1;
            state_d  = oth ? S_OWN1 : S_OWN0;
            burst_d  = ONE;
            rr_d     = oth;
          end else begin
            state_d  = S_IDLE;
            burst_d  = '0;
            rr_d     = oth;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Outputs
  always_comb begin
    wr_gnt_o = gnt;
    owner_o  = state_q;
  end

  // RAM command register; reset wins over any transfer accepted this cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
      mem_we_o    <= 1'b0;
      mem_re_o    <= 1'b0;
    end else if (rd_req_i) begin
      mem_addr_o  <= rd_addr_i;
      mem_we_o    <= 1'b0;
      mem_re_o    <= 1'b1;
    end else if (gnt != 2'b00) begin
      mem_addr_o  <= gnt[1] ? wr_addr1_i : wr_addr0_i;
      mem_wdata_o <= gnt[1] ? wr_data1_i : wr_data0_i;
      mem_we_o    <= 1'b1;
      mem_re_o    <= 1'b0;
    end else begin
      mem_we_o    <= 1'b0;
      mem_re_o    <= 1'b0;
    end
  end

endmodule
